cnn_conv_sequencer: RTL and testbench
=====================================

// Module: cnn_conv_sequencer
// PURPOSE
// Sequences one shared 3x3 MAC datapath across a whole feature map for one CNN conv layer.
// Walks output pixels in raster order, issuing 9 tap reads per pixel from a sync feature-map RAM.
// Accumulates, adds bias, saturates each result to 8 bits, and writes it to the output RAM with backpressure.
// Sits between the grayscale front end and the max-pool stage; one instance is reused per conv layer.
// PARAMETERS
// IMG_W   32  input map width (>=3)
// IMG_H   32  input map height (>=3)
// ADDR_W  10  RAM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
// clk      in   1       single clock, rising edge
// rst_n    in   1       synchronous reset, active-low
// start    in   1       begin a layer pass; sampled only in IDLE
// weights  in   72      9 x 8b unsigned taps, tap k = weights[8k+7:8k], k = ki*3+kj
// bias     in   8       unsigned bias added once per output pixel
// busy     out  1       high from the cycle after start is accepted until DONE exits
// done     out  1       one-cycle pulse after the final write handshake
// rd_en    out  1       feature-map read strobe
// rd_addr  out  ADDR_W  (row+ki)*IMG_W + (col+kj)
// rd_data  in   8       read data, valid exactly 1 cycle after rd_en
// wr_en    out  1       output write valid
// wr_addr  out  ADDR_W  row*(IMG_W-2) + col
// wr_data  out  8       saturated result
// wr_ready in   1       sink accepts the write when wr_en && wr_ready
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): state=IDLE; all outputs 0; counters and accumulator cleared. Reset mid-pass abandons the pass with no done pulse.
// - FSM: IDLE -start-> FETCH. FETCH (9 cycles, rd_en=1, tap 0..8) -> DRAIN (1 cycle).
//   DRAIN -> WRITE. WRITE holds until wr_ready=1.
//   On handshake: if last pixel -> DONE, else -> FETCH with next pixel. DONE (1 cycle, done=1) -> IDLE.
// - On accepted start, weights and bias are latched. Input changes while busy have no effect.
// - A start seen in any state other than IDLE is ignored. This includes the DONE cycle.
// - Accumulator is 20b unsigned. It clears at FETCH entry and adds rd_data*w[k] in the cycle that data returns.
//   The last product lands in DRAIN.
// - Result = acc + bias, computed in 20b, saturated: >255 -> 255. No truncation wrap.
// - WRITE: wr_en=1. wr_addr and wr_data are stable until the handshake. wr_ready low for N cycles adds N cycles.
// - Pixel order: col increments first. col wraps at IMG_W-3, then row increments. Last pixel is (IMG_H-3, IMG_W-3).
// - Timing: start accepted at cycle 0. First rd_en at cycle 1. First wr_en at cycle 11.
//   With no stalls: 11 cycles per pixel. Default map gives 900 pixels, done at cycle 9901.
// - rd_en=0 and wr_en=0 in IDLE, DRAIN and DONE. rd_en and wr_en are never high together.
// STRUCTURE
// - cnn_pkg holds PIX_W=8, ACC_W=20, the TAPS=9 constant, and the state enum {IDLE,FETCH,DRAIN,WRITE,DONE}.
// - Sub-module cnn_win_addr_gen holds the row/col/tap counters, rd_addr/wr_addr generation, and the last_tap/last_pixel flags.
// - The top level keeps the FSM, the latched weights, the MAC/accumulator and the saturation logic.
// TESTING
// 1 All weights 0, bias 3, random image: 900 writes, every wr_data=3, wr_addr 0..899 in order, done at cycle 9901.
// 2 Centre weight 1, others 0, bias 0, ramp image in[a]=a%256: wr_data at (r,c) = in[(r+1)*32+c+1]%256.
// 3 All pixels 255, all weights 255, bias 255: every wr_data=255 (saturation).
// 4 wr_ready low 5 cycles on pixel 7: wr_en/addr/data held stable, 900 writes total, done delayed by 5 cycles.
// 5 Pulse start again at cycles 50 and 9901 (DONE): ignored; exactly one done pulse; busy returns 0.
// 6 rst_n low at cycle 500 for 1 cycle: all outputs 0 next cycle, no done. A fresh start then completes 900 correct writes.

Source files
------------

// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN convolution sequencer slice:
//   PIX_W   - pixel / weight / bias width
//   ACC_W   - MAC accumulator width (holds 9 * 255 * 255 + 255 without wrap)
//   TAPS    - number of taps in the 3x3 window
//   state_t - sequencer FSM states
//   saturate() - clamps an accumulator value to the 8-bit pixel range
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int PIX_W   = 8;
    localparam int ACC_W   = 20;
    localparam int TAPS    = 9;
    localparam int MAX_PIX = (1 << PIX_W) - 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    // Clamp instead of truncating so that large sums never wrap to small values.
    function automatic logic [PIX_W-1:0] saturate(input logic [ACC_W-1:0] v);
        return (v > ACC_W'(MAX_PIX)) ? PIX_W'(MAX_PIX) : v[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/cnn_win_addr_gen.sv
// ---------------------------------------------------------------------------
// cnn_win_addr_gen
// Window address generator for the 3x3 convolution sequencer. Holds the
// output-pixel row/col counters and the ki/kj tap counters and turns them
// into feature-map read addresses and output write addresses.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   tap_adv     - advance to the next tap (one per FETCH cycle)
//   pix_adv     - advance to the next output pixel (write handshake)
//   rd_addr     - (row+ki)*IMG_W + (col+kj)
//   wr_addr     - row*(IMG_W-2) + col
//   tap_idx     - current tap number ki*3+kj
//   last_tap    - current tap is tap 8
//   last_pixel  - current pixel is (IMG_H-3, IMG_W-3)
// ---------------------------------------------------------------------------
module cnn_win_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tap_adv,
    input  logic              pix_adv,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        tap_idx,
    output logic              last_tap,
    output logic              last_pixel
);

    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] IN_PITCH  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] OUT_PITCH = ADDR_W'(IMG_W - 2);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [1:0]        ki_q, ki_d;
    logic [1:0]        kj_q, kj_d;

    assign last_tap   = (ki_q == 2'd2) && (kj_q == 2'd2);
    assign last_pixel = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign tap_idx    = 4'(ki_q) * 4'd3 + 4'(kj_q);
    assign rd_addr    = (row_q + ADDR_W'(ki_q)) * IN_PITCH + col_q + ADDR_W'(kj_q);
    assign wr_addr    = row_q * OUT_PITCH + col_q;

    // Taps walk kj fastest; after tap 8 the window returns to tap 0 ready for
    // the next pixel. Pixels walk col fastest and everything returns to zero
    // after the last pixel so the next pass starts from the origin.
    always_comb begin
        ki_d  = ki_q;
        kj_d  = kj_q;
        row_d = row_q;
        col_d = col_q;
        if (tap_adv) begin
            if (kj_q == 2'd2) begin
                kj_d = 2'd0;
                ki_d = (ki_q == 2'd2) ? 2'd0 : ki_q + 2'd1;
            end else begin
                kj_d = kj_q + 2'd1;
            end
        end
        if (pix_adv) begin
            if (last_pixel) begin
                row_d = '0;
                col_d = '0;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            ki_q  <= '0;
            kj_q  <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            ki_q  <= ki_d;
            kj_q  <= kj_d;
        end
    end

endmodule

// File: rtl/cnn_conv_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_conv_sequencer
// Runs one 3x3 convolution layer over a whole feature map using a single
// shared MAC. For every output pixel (raster order) it reads 9 taps from a
// synchronous feature-map RAM, accumulates rd_data*weight, adds the bias,
// saturates to 8 bits and writes the result with a valid/ready handshake.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   start             - begin a layer pass (only honoured while idle)
//   weights, bias     - 9 x 8b unsigned taps and 8b bias, latched at start
//   busy, done        - pass in progress / one-cycle completion pulse
//   rd_en, rd_addr    - feature-map read request
//   rd_data           - read data, valid one cycle after rd_en
//   wr_en, wr_addr,
//   wr_data, wr_ready - output write, accepted when wr_en && wr_ready
// ---------------------------------------------------------------------------
module cnn_conv_sequencer
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [TAPS*PIX_W-1:0] weights,
    input  logic [PIX_W-1:0]      bias,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [PIX_W-1:0]      rd_data,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [PIX_W-1:0]      wr_data,
    input  logic                  wr_ready
);

    state_t                  state_q, state_d;
    logic [TAPS*PIX_W-1:0]   weights_q, weights_d;
    logic [PIX_W-1:0]        bias_q, bias_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [3:0]              rd_tap_q, rd_tap_d;
    logic                    rd_en_q, rd_en_d;
    logic                    wr_en_q, wr_en_d;
    logic [PIX_W-1:0]        wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    tap_adv;
    logic                    pix_adv;
    logic [3:0]              tap_idx;
    logic                    last_tap;
    logic                    last_pixel;
    logic [PIX_W-1:0]        w_sel;
    logic [2*PIX_W-1:0]      prod;
    logic [ACC_W-1:0]        acc_sum;

    assign tap_adv = (state_q == FETCH);
    assign pix_adv = (state_q == WRITE) && wr_ready;

    cnn_win_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .tap_adv    (tap_adv),
        .pix_adv    (pix_adv),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr),
        .tap_idx    (tap_idx),
        .last_tap   (last_tap),
        .last_pixel (last_pixel)
    );

    // rd_tap_q remembers which tap the returning rd_data belongs to, since the
    // RAM answers one cycle after the request.
    assign w_sel   = weights_q[{rd_tap_q, 3'b000} +: PIX_W];
    assign prod    = (2*PIX_W)'(rd_data) * (2*PIX_W)'(w_sel);
    assign acc_sum = acc_q + ACC_W'(prod);

    // Next-state and registered-output logic. The accumulator adds each
    // product in the cycle its data returns, so the ninth product lands in
    // DRAIN; the saturated result is captured on the way into WRITE and
    // held there until the sink accepts it.
    always_comb begin
        state_d    = state_q;
        weights_d  = weights_q;
        bias_d     = bias_q;
        acc_d      = acc_q;
        wr_data_d  = wr_data_q;
        rd_valid_d = (state_q == FETCH);
        rd_tap_d   = tap_idx;

        if (rd_valid_q) begin
            acc_d = acc_sum;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    weights_d = weights;
                    bias_d    = bias;
                    acc_d     = '0;
                end
            end
            FETCH: begin
                if (last_tap) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d   = WRITE;
                wr_data_d = saturate(acc_sum + ACC_W'(bias_q));
            end
            WRITE: begin
                if (wr_ready) begin
                    if (last_pixel) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        acc_d   = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_en_d = (state_d == FETCH);
        wr_en_d = (state_d == WRITE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            weights_q  <= '0;
            bias_q     <= '0;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_tap_q   <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            weights_q  <= weights_d;
            bias_q     <= bias_d;
            acc_q      <= acc_d;
            rd_valid_q <= rd_valid_d;
            rd_tap_q   <= rd_tap_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cnn_conv_sequencer
// Bench for cnn_conv_sequencer: drives whole-layer passes with generated
// images and weights, models the feature-map RAM, collects every accepted
// write and compares against a direct 3x3 convolution of the image.
// ---------------------------------------------------------------------------
module tb_cnn_conv_sequencer;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int ADDR_W = 10;
    localparam int OUT_W  = IMG_W - 2;
    localparam int NPIX   = (IMG_W - 2) * (IMG_H - 2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [71:0]       weights = '0;
    logic [7:0]        bias = '0;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready = 1'b1;

    cnn_conv_sequencer #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .weights  (weights),
        .bias     (bias),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready)
    );

    always #5 clk = ~clk;

    // Feature-map RAM model with one cycle of read latency.
    logic [7:0] img [0:1023];
    always @(posedge clk) begin
        if (rd_en) rd_data <= img[rd_addr];
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference weights and bias kept separately from the DUT input ports.
    int wt [9];
    int bias_m;

    int check_cnt = 0;
    int pass_cnt  = 0;

    int base = 0;
    int wa [$];
    int wd [$];
    int write_count = 0;
    int first_rd = -1;
    int first_wr = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    int overlap = 0;
    int stall_cycles = 0;
    bit held_valid = 0;
    logic [ADDR_W-1:0] held_addr = '0;
    logic [7:0]        held_data = '0;

    int stall_pix = -1;
    int stall_len = 0;
    int stall_used = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_cnt++;
        if (observed == expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Direct convolution of the stored image for output pixel i.
    function automatic int expPix(input int i);
        int r = i / OUT_W;
        int c = i % OUT_W;
        int s = bias_m;
        for (int ki = 0; ki < 3; ki++)
            for (int kj = 0; kj < 3; kj++)
                s += int'(img[(r + ki) * IMG_W + c + kj]) * wt[ki * 3 + kj];
        return (s > 255) ? 255 : s;
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        int cyc;
        if (rst_n) begin
            cyc = edge_cnt - base;
            if (rd_en && first_rd < 0) first_rd = cyc;
            if (wr_en && first_wr < 0) first_wr = cyc;
            if (rd_en && wr_en) overlap++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (held_valid) begin
                checkOutput("hold_wr_en", int'(wr_en), 1);
                checkOutput("hold_wr_addr", int'(wr_addr), int'(held_addr));
                checkOutput("hold_wr_data", int'(wr_data), int'(held_data));
            end
            held_valid = wr_en && !wr_ready;
            if (held_valid) begin
                held_addr = wr_addr;
                held_data = wr_data;
                stall_cycles++;
            end
            if (wr_en && wr_ready) begin
                wa.push_back(int'(wr_addr));
                wd.push_back(int'(wr_data));
                write_count++;
            end
        end
    end

    // Sink backpressure: hold wr_ready low for stall_len cycles on one pixel.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_en && write_count == stall_pix && stall_used < stall_len) begin
                wr_ready = 1'b0;
                stall_used++;
            end else begin
                wr_ready = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input int mode);
        for (int a = 0; a < 1024; a++) begin
            case (mode)
                1:       img[a] = 8'(a % 256);
                2:       img[a] = 8'd255;
                default: img[a] = 8'($urandom_range(0, 255));
            endcase
        end
        for (int k = 0; k < 9; k++) begin
            case (mode)
                0:       wt[k] = 0;
                1:       wt[k] = (k == 4) ? 1 : 0;
                2:       wt[k] = 255;
                default: wt[k] = $urandom_range(0, 7);
            endcase
            weights[8*k +: 8] = 8'(wt[k]);
        end
        case (mode)
            0:       bias_m = 3;
            1:       bias_m = 0;
            2:       bias_m = 255;
            default: bias_m = $urandom_range(0, 255);
        endcase
        bias = 8'(bias_m);
    endtask

    task automatic startPass();
        wa.delete();
        wd.delete();
        write_count = 0;
        first_rd = -1;
        first_wr = -1;
        done_cnt = 0;
        done_cyc = -1;
        overlap = 0;
        stall_cycles = 0;
        held_valid = 0;
        stall_used = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base = edge_cnt - 1;
    endtask

    task automatic runToDone(input bit pulses);
        int cyc;
        bit fin = 0;
        for (int n = 0; n < 12000 && !fin; n++) begin
            @(posedge clk);
            #1;
            cyc = edge_cnt - base;
            if (pulses) begin
                start = (cyc == 50 || cyc == 9901);
                if (cyc == 50) begin
                    weights = {8'($urandom), 32'($urandom), 32'($urandom)};
                    bias    = 8'($urandom);
                end
            end
            if (cyc == 100) checkOutput("busy_mid", int'(busy), 1);
            if (done_cnt > 0 && cyc > done_cyc + 1) fin = 1;
        end
        start = 1'b0;
        checkOutput("pass_finished", int'(fin), 1);
    endtask

    task automatic checkPass(input int exp_done);
        checkOutput("write_count", wa.size(), NPIX);
        for (int i = 0; i < wa.size() && i < NPIX; i++) begin
            checkOutput($sformatf("wr_addr[%0d]", i), wa[i], i);
            checkOutput($sformatf("wr_data[%0d]", i), wd[i], expPix(i));
        end
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("done_cycle", done_cyc, exp_done);
        checkOutput("first_rd_cycle", first_rd, 1);
        checkOutput("first_wr_cycle", first_wr, 11);
        checkOutput("rd_wr_overlap", overlap, 0);
        checkOutput("stall_cycles", stall_cycles, stall_len);
        checkOutput("busy_after", int'(busy), 0);
        checkOutput("done_after", int'(done), 0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_rd_en"}, int'(rd_en), 0);
        checkOutput({tag, "_wr_en"}, int'(wr_en), 0);
        checkOutput({tag, "_rd_addr"}, int'(rd_addr), 0);
        checkOutput({tag, "_wr_addr"}, int'(wr_addr), 0);
        checkOutput({tag, "_wr_data"}, int'(wr_data), 0);
    endtask

    initial begin
        int cyc;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] pass A: zero weights, bias 3");
        applyStimulus(0);
        startPass();
        runToDone(0);
        checkPass(9901);

        $display("[TB] pass B: centre tap on ramp image");
        applyStimulus(1);
        startPass();
        runToDone(0);
        checkPass(9901);

        $display("[TB] pass C: saturation");
        applyStimulus(2);
        startPass();
        runToDone(0);
        checkPass(9901);

        $display("[TB] pass D: random data, 5-cycle stall on pixel 7");
        applyStimulus(3);
        stall_pix = 7;
        stall_len = 5;
        startPass();
        runToDone(0);
        checkPass(9906);
        stall_pix = -1;
        stall_len = 0;

        $display("[TB] pass E: start pulses while busy and during done");
        applyStimulus(3);
        startPass();
        runToDone(1);
        checkPass(9901);

        $display("[TB] pass F: reset mid-pass then fresh pass");
        applyStimulus(3);
        startPass();
        cyc = edge_cnt - base;
        while (cyc < 500) begin
            @(posedge clk);
            #1;
            cyc = edge_cnt - base;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkIdleOutputs("midreset");
        repeat (30) @(posedge clk);
        #1;
        checkOutput("no_done_after_reset", done_cnt, 0);
        checkOutput("busy_after_reset", int'(busy), 0);
        startPass();
        runToDone(0);
        checkPass(9901);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
